// File: rtl/zx_kbd_pkg.sv
// ---------------------------------------------------------------------------
// zx_kbd_pkg
// Shared definitions for the PS/2 to ZX Spectrum keyboard front end:
//   - half-row and column enums of the 8x5 Spectrum key matrix
//   - decoder state encoding
//   - PS/2 set-2 scancode constants (prefixes, F1, F11)
//   - map_key(): {ext,code} -> {hit,row[2:0],col[2:0]}
//   - map_comp(): composite (Shift+digit) keys, only when ZX_KBD_EXTKEYS_EN
//     is defined
// Configuration macro: ZX_KBD_EXTKEYS_EN
// ---------------------------------------------------------------------------
package zx_kbd_pkg;

    // Half-row index r corresponds to select line A[8+r].
    typedef enum logic [2:0] {
        HR_CS_V  = 3'd0,
        HR_A_G   = 3'd1,
        HR_Q_T   = 3'd2,
        HR_1_5   = 3'd3,
        HR_0_6   = 3'd4,
        HR_P_Y   = 3'd5,
        HR_ENT_H = 3'd6,
        HR_SP_B  = 3'd7
    } half_row_e;

    typedef enum logic [2:0] {
        KCOL_0 = 3'd0,
        KCOL_1 = 3'd1,
        KCOL_2 = 3'd2,
        KCOL_3 = 3'd3,
        KCOL_4 = 3'd4
    } col_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_REL     = 3'd2,
        ST_EXT_REL = 3'd3,
        ST_SKIP    = 3'd4
    } dec_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_REL   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F11   = 8'h78;

    // Pause sends E1 followed by 7 more bytes that carry no key information.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic [6:0] map_key(input logic ext, input logic [7:0] code);
        logic      hit;
        half_row_e r;
        col_e      c;
        hit = 1'b1;
        r   = HR_CS_V;
        c   = KCOL_0;
        if (ext) begin
            if (code == 8'h14) begin r = HR_SP_B; c = KCOL_1; end  // RCtrl -> SShift
            else hit = 1'b0;
        end else begin
            case (code)
                8'h12, 8'h59: begin r = HR_CS_V;  c = KCOL_0; end  // L/R Shift -> CShift
                8'h1A: begin r = HR_CS_V;  c = KCOL_1; end
                8'h22: begin r = HR_CS_V;  c = KCOL_2; end
                8'h21: begin r = HR_CS_V;  c = KCOL_3; end
                8'h2A: begin r = HR_CS_V;  c = KCOL_4; end
                8'h1C: begin r = HR_A_G;   c = KCOL_0; end
                8'h1B: begin r = HR_A_G;   c = KCOL_1; end
                8'h23: begin r = HR_A_G;   c = KCOL_2; end
                8'h2B: begin r = HR_A_G;   c = KCOL_3; end
                8'h34: begin r = HR_A_G;   c = KCOL_4; end
                8'h15: begin r = HR_Q_T;   c = KCOL_0; end
                8'h1D: begin r = HR_Q_T;   c = KCOL_1; end
                8'h24: begin r = HR_Q_T;   c = KCOL_2; end
                8'h2D: begin r = HR_Q_T;   c = KCOL_3; end
                8'h2C: begin r = HR_Q_T;   c = KCOL_4; end
                8'h16: begin r = HR_1_5;   c = KCOL_0; end
                8'h1E: begin r = HR_1_5;   c = KCOL_1; end
                8'h26: begin r = HR_1_5;   c = KCOL_2; end
                8'h25: begin r = HR_1_5;   c = KCOL_3; end
                8'h2E: begin r = HR_1_5;   c = KCOL_4; end
                8'h45: begin r = HR_0_6;   c = KCOL_0; end
                8'h46: begin r = HR_0_6;   c = KCOL_1; end
                8'h3E: begin r = HR_0_6;   c = KCOL_2; end
                8'h3D: begin r = HR_0_6;   c = KCOL_3; end
                8'h36: begin r = HR_0_6;   c = KCOL_4; end
                8'h4D: begin r = HR_P_Y;   c = KCOL_0; end
                8'h44: begin r = HR_P_Y;   c = KCOL_1; end
                8'h43: begin r = HR_P_Y;   c = KCOL_2; end
                8'h3C: begin r = HR_P_Y;   c = KCOL_3; end
                8'h35: begin r = HR_P_Y;   c = KCOL_4; end
                8'h5A: begin r = HR_ENT_H; c = KCOL_0; end
                8'h4B: begin r = HR_ENT_H; c = KCOL_1; end
                8'h42: begin r = HR_ENT_H; c = KCOL_2; end
                8'h3B: begin r = HR_ENT_H; c = KCOL_3; end
                8'h33: begin r = HR_ENT_H; c = KCOL_4; end
                8'h29: begin r = HR_SP_B;  c = KCOL_0; end
                8'h14: begin r = HR_SP_B;  c = KCOL_1; end  // LCtrl -> SShift
                8'h3A: begin r = HR_SP_B;  c = KCOL_2; end
                8'h31: begin r = HR_SP_B;  c = KCOL_3; end
                8'h32: begin r = HR_SP_B;  c = KCOL_4; end
                default: hit = 1'b0;
            endcase
        end
        return {hit, r, c};
    endfunction

`ifdef ZX_KBD_EXTKEYS_EN
    // Composite keys: returns {hit, idx[2:0]}; idx selects a bit of ext_caps.
    //   0 Backspace (CS+0), 1 Left (CS+5), 2 Down (CS+6), 3 Up (CS+7), 4 Right (CS+8)
    function automatic logic [3:0] map_comp(input logic ext, input logic [7:0] code);
        logic [3:0] res;
        res = 4'b0000;
        if (!ext && code == 8'h66) res = {1'b1, 3'd0};
        if (ext) begin
            case (code)
                8'h6B:   res = {1'b1, 3'd1};
                8'h72:   res = {1'b1, 3'd2};
                8'h75:   res = {1'b1, 3'd3};
                8'h74:   res = {1'b1, 3'd4};
                default: res = 4'b0000;
            endcase
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host receiver: 2-FF synchronisers on clock and data, an
// 11-bit frame shifter sampled on each PS/2 clock fall, start/stop/odd-parity
// check, and an idle timeout that realigns to a frame boundary.
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   ps2_clk_i     raw PS/2 clock (asynchronous)
//   ps2_dat_i     raw PS/2 data (asynchronous)
//   code_valid_o  1-cycle pulse when a good frame has been received
//   code_o        received data byte, valid with code_valid_o
// ---------------------------------------------------------------------------
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 14000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       code_valid_o,
    output logic [7:0] code_o
);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [1:0]        ck_sync_q;
    logic [1:0]        dt_sync_q;
    logic              ck_old_q;
    logic [9:0]        shift_q,      shift_d;
    logic [3:0]        bit_cnt_q,    bit_cnt_d;
    logic [IDLE_W-1:0] idle_q,       idle_d;
    logic              code_valid_q, code_valid_d;
    logic [7:0]        code_q,       code_d;

    logic        ck_s;
    logic        dt_s;
    logic        fall;
    logic [10:0] frame;
    logic        frame_ok;

    assign ck_s = ck_sync_q[1];
    assign dt_s = dt_sync_q[1];
    assign fall = ck_old_q & ~ck_s;

    // On the stop-bit fall, the first ten bits are in shift_q and the stop
    // bit is still on the synchronised data line.
    assign frame    = {dt_s, shift_q};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        idle_d       = idle_q;
        code_valid_d = 1'b0;
        code_d       = code_q;
        if (fall) begin
            idle_d  = '0;
            shift_d = {dt_s, shift_q[9:1]};
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d    = 4'd0;
                code_valid_d = frame_ok;
                code_d       = frame[8:1];
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end else begin
            // Line quiet too long: abandon any partial frame.
            bit_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ck_sync_q    <= 2'b11;
            dt_sync_q    <= 2'b11;
            ck_old_q     <= 1'b1;
            shift_q      <= '0;
            bit_cnt_q    <= 4'd0;
            idle_q       <= '0;
            code_valid_q <= 1'b0;
            code_q       <= 8'h00;
        end else begin
            ck_sync_q    <= {ck_sync_q[0], ps2_clk_i};
            dt_sync_q    <= {dt_sync_q[0], ps2_dat_i};
            ck_old_q     <= ck_s;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_q       <= idle_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
        end
    end

    assign code_valid_o = code_valid_q;
    assign code_o       = code_q;

endmodule

// File: rtl/zx_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// zx_ps2_keyboard
// PS/2 keyboard front end for a ZX Spectrum ULA. Received set-2 scancodes
// are decoded (E0/F0 prefixes, E1 Pause skipping) into the 8x5 key matrix;
// port #FE reads are answered combinationally from the half-row selects.
// Configuration macro: ZX_KBD_EXTKEYS_EN (arrows/Backspace as Shift+digit).
// Ports:
//   CLK      system clock (ULA clock)
//   nRESET   asynchronous active-low reset
//   PS2_CLK  PS/2 clock line
//   PS2_DAT  PS/2 data line
//   A        CPU address; A[15:8] are active-low half-row selects
//   KEYB     matrix column read, active-low
//   F11      high while F11 is held
//   F1       high while F1 is held
// ---------------------------------------------------------------------------
module zx_ps2_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 14000
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic [15:0] A,
    output logic [4:0]  KEYB,
    output logic        F11,
    output logic        F1
);
    logic       code_valid;
    logic [7:0] code;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i       (CLK),
        .rst_ni      (nRESET),
        .ps2_clk_i   (PS2_CLK),
        .ps2_dat_i   (PS2_DAT),
        .code_valid_o(code_valid),
        .code_o      (code)
    );

    dec_state_e      state_q,  state_d;
    logic [2:0]      skip_q,   skip_d;
    logic [7:0][4:0] matrix_q, matrix_d;
    logic            f1_q,     f1_d;
    logic            f11_q,    f11_d;
    logic [7:0][4:0] eff;
    logic [4:0]      col_hit;
    logic            ext_flag;
    logic            rel_flag;
    logic [6:0]      key_lu;
    logic            unused_addr_lo;

`ifdef ZX_KBD_EXTKEYS_EN
    logic [4:0] ext_caps_q, ext_caps_d;
    logic [3:0] comp_lu;
    assign comp_lu = map_comp(ext_flag, code);
`endif

    assign ext_flag = (state_q == ST_EXT) || (state_q == ST_EXT_REL);
    assign rel_flag = (state_q == ST_REL) || (state_q == ST_EXT_REL);
    assign key_lu   = map_key(ext_flag, code);

    // Decoder: prefixes accumulate in the state, the first non-prefix byte
    // applies the key event and returns to IDLE.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        matrix_d = matrix_q;
        f1_d     = f1_q;
        f11_d    = f11_q;
`ifdef ZX_KBD_EXTKEYS_EN
        ext_caps_d = ext_caps_q;
`endif
        if (code_valid) begin
            if (state_q == ST_SKIP) begin
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) state_d = ST_IDLE;
            end else if (code == SC_PAUSE) begin
                skip_d  = PAUSE_SKIP;
                state_d = ST_SKIP;
            end else if (code == SC_EXT) begin
                // F0 E0 is accepted as an alias of E0 F0.
                state_d = rel_flag ? ST_EXT_REL : ST_EXT;
            end else if (code == SC_REL) begin
                state_d = ext_flag ? ST_EXT_REL : ST_REL;
            end else begin
                state_d = ST_IDLE;
                if (key_lu[6]) matrix_d[key_lu[5:3]][key_lu[2:0]] = ~rel_flag;
                if (!ext_flag && code == SC_F1)  f1_d  = ~rel_flag;
                if (!ext_flag && code == SC_F11) f11_d = ~rel_flag;
`ifdef ZX_KBD_EXTKEYS_EN
                if (comp_lu[3]) ext_caps_d[comp_lu[2:0]] = ~rel_flag;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            skip_q   <= 3'd0;
            matrix_q <= '0;
            f1_q     <= 1'b0;
            f11_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            matrix_q <= matrix_d;
            f1_q     <= f1_d;
            f11_q    <= f11_d;
        end
    end

`ifdef ZX_KBD_EXTKEYS_EN
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) ext_caps_q <= '0;
        else         ext_caps_q <= ext_caps_d;
    end
`endif

    // Composite keys are ORed on top of the physical matrix so that their
    // release never clears a physically held CShift or digit.
    always_comb begin
        eff = matrix_q;
`ifdef ZX_KBD_EXTKEYS_EN
        eff[HR_CS_V][KCOL_0] = matrix_q[HR_CS_V][KCOL_0] | (|ext_caps_q);
        eff[HR_0_6][KCOL_0]  = matrix_q[HR_0_6][KCOL_0]  | ext_caps_q[0];
        eff[HR_1_5][KCOL_4]  = matrix_q[HR_1_5][KCOL_4]  | ext_caps_q[1];
        eff[HR_0_6][KCOL_4]  = matrix_q[HR_0_6][KCOL_4]  | ext_caps_q[2];
        eff[HR_0_6][KCOL_3]  = matrix_q[HR_0_6][KCOL_3]  | ext_caps_q[3];
        eff[HR_0_6][KCOL_2]  = matrix_q[HR_0_6][KCOL_2]  | ext_caps_q[4];
`endif
    end

    // Every selected half-row pulls its pressed columns low (wired-AND).
    always_comb begin
        col_hit = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                col_hit[c] = col_hit[c] | (eff[r][c] & ~A[8+r]);
            end
        end
    end

    assign KEYB           = ~col_hit;
    assign F1             = f1_q;
    assign F11            = f11_q;
    assign unused_addr_lo = ^A[7:0];

endmodule
